// File: rtl/ram_be_clr.sv
// ---------------------------------------------------------------------------
// ram_be_clr : simple-dual-port RAM with byte enables, write-first
//              forwarding, selectable read latency and a built-in clear.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_be_clr #(
  parameter int ADDR_LEN = 10,
  parameter int DATA_LEN = 32,
  parameter int OUT_REG  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_LEN-1:0]   wr_addr,
  input  logic [DATA_LEN-1:0]   wr_data,
  input  logic [DATA_LEN/8-1:0] wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_LEN-1:0]   rd_addr,
  output logic [DATA_LEN-1:0]   Q,
  output logic                  Q_valid
);

  localparam int DEPTH  = 2**ADDR_LEN;
  localparam int BE_LEN = DATA_LEN/8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [0:0]          state;
  logic [ADDR_LEN-1:0] cnt;
  logic                idle;
  logic                wr_ok;
  logic                rd_ok;
  logic                hit;
  logic [DATA_LEN-1:0] old_word;
  logic [DATA_LEN-1:0] rd_word;
  logic                v1;
  logic [DATA_LEN-1:0] d1;

  assign idle  = (state == IDLE);
  assign busy  = (state == CLEAR);
  assign wr_ok = idle && wr_en;
  assign rd_ok = idle && rd_en;
  assign hit   = wr_en && (wr_addr == rd_addr);
  assign old_word = mem[rd_addr];

  // Write-first: enabled bytes of a colliding write replace the stored bytes.
  generate
    for (genvar i = 0; i < BE_LEN; i++) begin : g_merge
      assign rd_word[8*i +: 8] = (hit && wr_be[i]) ? wr_data[8*i +: 8]
                                                   : old_word[8*i +: 8];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < BE_LEN; i++) begin
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      v1    <= 1'b0;
      d1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (cnt == {ADDR_LEN{1'b1}}) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
      endcase
      v1 <= rd_ok;
      if (rd_ok) d1 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                v2;
      logic [DATA_LEN-1:0] d2;
      always_ff @(posedge CLK) begin
        if (RST) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign Q       = d2;
      assign Q_valid = v2;
    end else begin : g_no_out_reg
      assign Q       = d1;
      assign Q_valid = v1;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ram_be_clr.sv
// ---------------------------------------------------------------------------
// tb_ram_be_clr : directed self-checking bench, OUT_REG=0 and OUT_REG=1 side by side.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_be_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_start;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        busy0, busy1;
  logic [31:0] q0, q1;
  logic        qv0, qv1;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  ram_be_clr #(.ADDR_LEN(4), .DATA_LEN(32), .OUT_REG(0)) dut0 (
    .CLK(clk), .RST(rst), .clr_start(clr_start), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .Q(q0), .Q_valid(qv0)
  );

  ram_be_clr #(.ADDR_LEN(4), .DATA_LEN(32), .OUT_REG(1)) dut1 (
    .CLK(clk), .RST(rst), .clr_start(clr_start), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .Q(q1), .Q_valid(qv1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    clr_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 16; i++) write(4'(i), 32'hFFFF_FFFF, 4'hF);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    check("reset_busy",  {31'd0, busy0}, 32'd0);
    check("reset_q",     q0, 32'd0);
    check("reset_qv",    {31'd0, qv0}, 32'd0);
    check("reset_q1",    q1, 32'd0);
    rst = 1'b0;

    // Byte enables
    write(4'd5, 32'h1122_3344, 4'hF);
    write(4'd5, 32'hAABB_CCDD, 4'b0101);
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    check("be_q",        q0, 32'h11BB_33DD);
    check("be_qv",       {31'd0, qv0}, 32'd1);
    check("be_qv1_early",{31'd0, qv1}, 32'd0);
    tick();
    check("be_qv_pulse", {31'd0, qv0}, 32'd0);
    check("be_q_hold",   q0, 32'h11BB_33DD);
    check("be_q1",       q1, 32'h11BB_33DD);
    check("be_qv1",      {31'd0, qv1}, 32'd1);
    tick();
    check("be_qv1_pulse",{31'd0, qv1}, 32'd0);

    // Collision forwarding
    write(4'd3, 32'h0, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF; wr_be = 4'b1100;
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    idle_inputs();
    check("coll_q",      q0, 32'hDEAD_0000);
    check("coll_qv",     {31'd0, qv0}, 32'd1);
    tick();
    check("coll_q1",     q1, 32'hDEAD_0000);

    // Latency with output register
    write(4'd0, 32'hA, 4'hF);
    write(4'd1, 32'hB, 4'hF);
    write(4'd2, 32'hC, 4'hF);
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    check("lat_qv1_k",   {31'd0, qv1}, 32'd0);
    check("lat_q0_a",    q0, 32'hA);
    rd_addr = 4'd1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h55; wr_be = 4'hF;
    tick();
    wr_en = 1'b0;
    check("lat_qv1_a",   {31'd0, qv1}, 32'd1);
    check("lat_q1_a",    q1, 32'hA);
    rd_addr = 4'd2;
    tick();
    rd_en = 1'b0;
    check("lat_qv1_b",   {31'd0, qv1}, 32'd1);
    check("lat_q1_b",    q1, 32'hB);
    tick();
    check("lat_qv1_c",   {31'd0, qv1}, 32'd1);
    check("lat_q1_c",    q1, 32'hC);
    tick();
    check("lat_qv1_end", {31'd0, qv1}, 32'd0);

    // Full clear
    fill_ones();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      if (n == 1) begin
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h1234; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 4'd7;
      end
      tick();
      idle_inputs();
      check("clr_no_qv", {31'd0, qv0}, 32'd0);
    end
    check("clr_busy_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      check($sformatf("clr_rd%0d", i), q0, 32'h0);
    end
    rd_en = 1'b0;
    tick();

    // Reset in the middle of a clear
    fill_ones();
    rd_en = 1'b1; rd_addr = 4'd15;
    tick();
    rd_en = 1'b0;
    check("rmc_pre_q",   q0, 32'hFFFF_FFFF);
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmc_busy",    {31'd0, busy0}, 32'd0);
    check("rmc_q",       q0, 32'h0);
    check("rmc_qv",      {31'd0, qv0}, 32'd0);
    check("rmc_q1",      q1, 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      check($sformatf("rmc_rd%0d", i), q0, (i < 6) ? 32'h0 : 32'hFFFF_FFFF);
    end
    rd_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
